load_store_unit: RTL and testbench

Sits between the pipeline's memory stage and the word-addressed 256-byte data memory, i.e. directly upstream of the data memory. It turns CPU load/store requests (byte, halfword, word; signed or unsigned loads) into word-wide memory reads and writes. Sub-word stores are handled as a read-modify-write sequence. It also flags misaligned or out-of-range accesses. It is a multi-cycle unit with a Req/Ready/Done handshake that the control unit uses to stall.

---
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a word-addressed data memory.
// Handles byte/half/word loads with extension, sub-word stores by read-modify-write, and access faults.
module load_store_unit #(
  parameter  int MemWords = 64,
  localparam int AW       = $clog2(MemWords)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_req,
  input  logic          i_req_write,
  input  logic [1:0]    i_size,
  input  logic          i_signed,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_store_data,
  output logic          o_ready,
  output logic          o_done,
  output logic          o_fault,
  output logic [31:0]   o_load_data,
  output logic [AW-1:0] o_mem_address,
  output logic [31:0]   o_mem_write_data,
  output logic          o_mem_read,
  output logic          o_mem_write,
  input  logic [31:0]   i_mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t r_state, w_state_next;

  logic          r_done, r_fault, r_write, r_signed;
  logic [1:0]    r_size, r_lane;
  logic [31:0]   r_store_data, r_load_data, r_mem_write_data;
  logic [AW-1:0] r_mem_address;

  logic        w_accept, w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_extended, w_merged;

  assign w_accept = i_req && (r_state == S_IDLE);
  assign w_fault  = (i_size == 2'b11)
                 || (i_size == 2'b01 && i_addr[0])
                 || (i_size == 2'b10 && i_addr[1:0] != 2'b00)
                 || (i_addr >= 32'(4 * MemWords));

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_fault) begin
          if (i_req_write && i_size == 2'b10) w_state_next = S_WR;
          else                                w_state_next = S_RD;
        end
      end
      S_RD:    w_state_next = r_write ? S_WR : S_IDLE;
      S_WR:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Big-endian lane extraction from the word being read, plus the store merge into it.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = r_lane[1] ? i_mem_read_data[15:0] : i_mem_read_data[31:16];
    w_extended = i_mem_read_data;
    w_merged   = i_mem_read_data;
    case (r_lane)
      2'd0:    w_byte = i_mem_read_data[31:24];
      2'd1:    w_byte = i_mem_read_data[23:16];
      2'd2:    w_byte = i_mem_read_data[15:8];
      default: w_byte = i_mem_read_data[7:0];
    endcase
    if (r_size == 2'b00) begin
      w_extended = {{24{r_signed & w_byte[7]}}, w_byte};
      case (r_lane)
        2'd0:    w_merged[31:24] = r_store_data[7:0];
        2'd1:    w_merged[23:16] = r_store_data[7:0];
        2'd2:    w_merged[15:8]  = r_store_data[7:0];
        default: w_merged[7:0]   = r_store_data[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      w_extended = {{16{r_signed & w_half[15]}}, w_half};
      if (r_lane[1]) w_merged[15:0]  = r_store_data[15:0];
      else           w_merged[31:16] = r_store_data[15:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_done           <= 1'b0;
      r_fault          <= 1'b0;
      r_write          <= 1'b0;
      r_signed         <= 1'b0;
      r_size           <= 2'b00;
      r_lane           <= 2'b00;
      r_store_data     <= 32'h0;
      r_load_data      <= 32'h0;
      r_mem_write_data <= 32'h0;
      r_mem_address    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_fault) begin
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end else begin
              r_write       <= i_req_write;
              r_signed      <= i_signed;
              r_size        <= i_size;
              r_lane        <= i_addr[1:0];
              r_store_data  <= i_store_data;
              r_mem_address <= i_addr[AW+1:2];
              if (i_req_write && i_size == 2'b10) r_mem_write_data <= i_store_data;
            end
          end
        end
        S_RD: begin
          if (r_write) begin
            r_mem_write_data <= w_merged;
          end else begin
            r_load_data <= w_extended;
            r_done      <= 1'b1;
          end
        end
        S_WR:    r_done <= 1'b1;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign o_ready          = (r_state == S_IDLE);
  assign o_mem_read       = (r_state == S_RD);
  assign o_mem_write      = (r_state == S_WR);
  assign o_done           = r_done;
  assign o_fault          = r_fault;
  assign o_load_data      = r_load_data;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word memory model that writes on the negedge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_write, sgn;
  logic [1:0]  size;
  logic [31:0] addr, store_data;
  logic        ready, done, fault, mem_read, mem_write;
  logic [31:0] load_data, mem_write_data, mem_read_data;
  logic [5:0]  mem_address;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem[mem_address];

  load_store_unit #(.MemWords(64)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_req_write(req_write),
    .i_size(size), .i_signed(sgn), .i_addr(addr), .i_store_data(store_data),
    .o_ready(ready), .o_done(done), .o_fault(fault), .o_load_data(load_data),
    .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .i_mem_read_data(mem_read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; req_write = w; size = s; sgn = sg; addr = a; store_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, s, sg, a, 32'h0);
    tick();
    check({tag, " rd"}, 32'(mem_read), 32'd1);
    check({tag, " addr"}, 32'(mem_address), a >> 2);
    idle();
    tick();
    check({tag, " done"}, {30'd0, done, fault}, 32'd2);
    check({tag, " data"}, load_data, exp);
    $display("txn %s addr=0x%02h data=0x%08h", tag, a, load_data);
  endtask

  task automatic do_sw(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, 2'b10, 1'b0, a, d);
    tick();
    check({tag, " rd/wr"}, {30'd0, mem_read, mem_write}, 32'd1);
    check({tag, " addr"}, 32'(mem_address), a >> 2);
    check({tag, " wdata"}, mem_write_data, d);
    idle();
    tick();
    check({tag, " done"}, {30'd0, done, fault}, 32'd2);
    check({tag, " mem"}, mem[a[7:2]], d);
    $display("txn %s addr=0x%02h data=0x%08h", tag, a, d);
  endtask

  task automatic do_fault(input string tag, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] exp_ld);
    drive(1'b1, w, s, 1'b0, a, 32'h55);
    tick();
    check({tag, " done/fault"}, {30'd0, done, fault}, 32'd3);
    check({tag, " no access"}, {30'd0, mem_read, mem_write}, 32'd0);
    check({tag, " ready"}, 32'(ready), 32'd1);
    check({tag, " load_data"}, load_data, exp_ld);
    idle();
    tick();
    check({tag, " done drop"}, 32'(done), 32'd0);
    $display("txn %s addr=0x%03h faulted", tag, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("reset ready", 32'(ready), 32'd1);
    check("reset flags", {28'd0, done, fault, mem_read, mem_write}, 32'd0);
    check("reset load_data", load_data, 32'h0);
    check("reset wdata", mem_write_data, 32'h0);
    check("reset maddr", 32'(mem_address), 32'd0);
    rst = 1'b0;

    do_sw("preload", 32'h14, 32'h80FF7F01);
    do_load("LB", 2'b00, 1'b1, 32'h14, 32'hFFFFFF80);
    do_load("LBU", 2'b00, 1'b0, 32'h14, 32'h00000080);
    do_load("LH", 2'b01, 1'b1, 32'h16, 32'h00007F01);

    // Sub-word store: one read cycle, one write cycle, then Done.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h15, 32'h000000AB);
    tick();
    check("SB rd/wr 1", {30'd0, mem_read, mem_write}, 32'd2);
    idle();
    tick();
    check("SB rd/wr 2", {30'd0, mem_read, mem_write}, 32'd1);
    check("SB wdata", mem_write_data, 32'h80AB7F01);
    check("SB addr", 32'(mem_address), 32'd5);
    check("SB early done", 32'(done), 32'd0);
    tick();
    check("SB done", {30'd0, done, fault}, 32'd2);
    check("SB mem", mem[5], 32'h80AB7F01);
    $display("txn SB addr=0x15 word=0x%08h", mem[5]);

    do_sw("SW", 32'h00, 32'hDEADBEEF);
    do_load("LW", 2'b10, 1'b0, 32'h00, 32'hDEADBEEF);

    do_fault("LW@02", 1'b0, 2'b10, 32'h02, 32'hDEADBEEF);
    do_fault("LH@03", 1'b0, 2'b01, 32'h03, 32'hDEADBEEF);
    do_fault("SB@100", 1'b1, 2'b00, 32'h100, 32'hDEADBEEF);
    do_fault("size11", 1'b0, 2'b11, 32'h14, 32'hDEADBEEF);
    check("fault mem", mem[5], 32'h80AB7F01);

    // Back-to-back: Req held through RD, second request taken in the load's Done cycle.
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
    tick();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678);
    check("b2b rd busy", {30'd0, ready, mem_read}, 32'd1);
    check("b2b rd addr", 32'(mem_address), 32'd5);
    tick();
    check("b2b ld done", {29'd0, done, ready, mem_write}, 32'd6);
    check("b2b ld data", load_data, 32'h00000080);
    tick();
    check("b2b st wr", {30'd0, mem_read, mem_write}, 32'd1);
    check("b2b st addr", 32'(mem_address), 32'd2);
    idle();
    tick();
    check("b2b st done", 32'(done), 32'd1);
    check("b2b st mem", mem[2], 32'h12345678);
    $display("txn b2b load=0x%08h store=0x%08h", load_data, mem[2]);

    // Reset during the RD of a sub-word store, with Req raised under reset.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h15, 32'h000000CD);
    tick();
    check("rst rd", 32'(mem_read), 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    tick();
    check("rst flags", {28'd0, done, fault, mem_read, mem_write}, 32'd0);
    check("rst ready", 32'(ready), 32'd1);
    check("rst load_data", load_data, 32'h0);
    check("rst wdata", mem_write_data, 32'h0);
    check("rst maddr", 32'(mem_address), 32'd0);
    tick();
    check("rst req ignored", {30'd0, mem_read, ready}, 32'd1);
    rst = 1'b0;
    idle();
    tick();
    check("post rst", {29'd0, ready, done, mem_write}, 32'd4);
    check("post rst mem", mem[5], 32'h80AB7F01);
    $display("txn reset-in-RD word5=0x%08h", mem[5]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
